acs_pm_unit: RTL
================

# acs_pm_unit

Add-compare-select and path-metric stage of the rate-1/2, 64-state hard-decision Viterbi decoder. Sits directly downstream of the per-state branch-metric cells: it consumes each state's two 2-bit branch metrics every symbol, updates the 64 path metrics, and emits one survivor-decision bit per state to the traceback memory. Path metrics are held internally, one symbol per accepted beat.

## Interface
Parameters:
- NUM_STATES, 64, trellis states (power of two)
- BM_W, 2, branch-metric width
- PM_W, 8, path-metric width
- INIT_BIAS, 64, start metric of every state except state 0 at frame start / reset

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  branch metrics valid this cycle; no backpressure, block accepts every valid beat
- frame_start  input  1  qualified by in_valid; this symbol is the first of a frame
- bm_flat  input  NUM_STATES*2*BM_W  per state s: bits [s*4+1:s*4] = path_0 metric, [s*4+3:s*4+2] = path_1 metric
- out_valid  output  1  survivor and best_state valid
- survivor  output  NUM_STATES  bit s = 1 when path_1 won into state s
- best_state  output  log2(NUM_STATES)  index of minimum updated path metric

## Operation
- Predecessors of state s: p0 = (2s) mod NUM_STATES via path_0, p1 = (2s+1) mod NUM_STATES via path_1.
- Per accepted beat: c0 = pm[p0] + bm0[s], c1 = pm[p1] + bm1[s]; new pm[s] = min(c0, c1); survivor[s] = (c1 < c0). Tie selects path_0 (survivor 0).
- Sums computed at PM_W+1 bits internally; no saturation needed given normalisation.
- Normalisation: if every new pm has bit PM_W-1 set, clear that bit in all new metrics in the same update (subtract 2^(PM_W-1)). Relative order of metrics is preserved.
- Frame start: when in_valid && frame_start, the ACS uses the init vector (pm[0]=0, others INIT_BIAS) as previous metrics instead of the stored ones.
- in_valid low: metrics, survivor and best_state hold; out_valid low.
- Reset: pm[0]=0, pm[1..63]=INIT_BIAS; out_valid=0; survivor=0; best_state=0.

## Timing
- Latency 1: beat accepted at edge N -> out_valid high, survivor/best_state valid after edge N, for exactly one cycle per beat.
- Back-to-back beats every cycle supported; metrics updated at each accepting edge.
- Reset mid-stream: all state returns to reset values asynchronously; the beat in flight is discarded (no out_valid).
- frame_start on consecutive beats: each re-initialises; no metric history survives.
- Critical path: adder + comparator + 64-wide MSB-AND for normalisation (+ min tree when enabled); single cycle, no internal pipelining.

## Configuration
- ACS_BEST_STATE_EN defined: combinational min-search over new metrics (lowest index wins ties), registered into best_state with survivor.
- Not defined: best_state held at 0; no min-search logic.

## Structure
- Shared package viterbi_pkg: NUM_STATES, BM_W, PM_W, INIT_BIAS, STATE_W = log2(NUM_STATES), pred0/pred1 index functions, init-vector constant.
- Sub-module acs_node: one per state (generate loop); two adders, compare, select, survivor bit; top holds metric registers, normalisation and best-state search.

## Test plan
- Reset -> pm[0]=0, pm[1..63]=64, out_valid=0, survivor=0, best_state=0.
- frame_start beat, all bm0=0, bm1=2 -> next cycle out_valid=1, survivor=all 0, pm[0]=pm[32]=0, others 64; best_state=0 (with macro).
- Equal predecessor metrics and bm0=bm1=1 on all states -> survivor=all 0 (tie rule).
- 200 beats, all bm=2 -> every metric remains < 256, min metric ≤ 129, relative differences unchanged across each normalisation edge.
- in_valid low for 5 cycles between beats -> out_valid low, metrics unchanged; next beat matches a golden model with no gap.
- Async rst asserted mid-stream, then frame_start beat with bm1[5]=0, bm0[5]=3 and others 2 -> survivor[5]=1, outputs match golden model from init vector.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants: trellis size, metric widths, predecessor
// indexing and the frame-start metric vector.
package viterbi_pkg;

  localparam int NUM_STATES = 64;
  localparam int BM_W       = 2;
  localparam int PM_W       = 8;
  localparam int INIT_BIAS  = 64;
  localparam int STATE_W    = $clog2(NUM_STATES);

  // Predecessor of state s along path_0 / path_1 in an n-state shift-register trellis.
  function automatic int pred0(input int s, input int n);
    return (2 * s) % n;
  endfunction

  function automatic int pred1(input int s, input int n);
    return (2 * s + 1) % n;
  endfunction

  // Frame-start metric vector: state 0 is the known start state, all others are biased.
  function automatic int init_metric(input int s, input int bias);
    return (s == 0) ? 0 : bias;
  endfunction

endpackage

// File: rtl/acs_node.sv
// Single-state add-compare-select: two candidate sums, pick the smaller,
// ties resolved towards path_0.
module acs_node #(
  parameter int BM_W = viterbi_pkg::BM_W,
  parameter int PM_W = viterbi_pkg::PM_W
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  output logic [PM_W-1:0] new_pm,
  output logic            sel
);

  logic [PM_W:0] c0;
  logic [PM_W:0] c1;

  // Sums carry one extra bit so the compare is exact; normalisation keeps the
  // winner inside PM_W bits.
  always_comb begin
    c0     = {1'b0, pm0} + (PM_W+1)'(bm0);
    c1     = {1'b0, pm1} + (PM_W+1)'(bm1);
    sel    = (c1 < c0);
    new_pm = sel ? c1[PM_W-1:0] : c0[PM_W-1:0];
  end

endmodule

// File: rtl/acs_pm_unit.sv
// ACS and path-metric stage of the 64-state Viterbi decoder.
// Optional ACS_BEST_STATE_EN adds a registered min-metric state search.
module acs_pm_unit
  import viterbi_pkg::*;
#(
  parameter int NUM_STATES = viterbi_pkg::NUM_STATES,
  parameter int BM_W       = viterbi_pkg::BM_W,
  parameter int PM_W       = viterbi_pkg::PM_W,
  parameter int INIT_BIAS  = viterbi_pkg::INIT_BIAS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          frame_start,
  input  logic [NUM_STATES*2*BM_W-1:0]  bm_flat,
  output logic                          out_valid,
  output logic [NUM_STATES-1:0]         survivor,
  output logic [$clog2(NUM_STATES)-1:0] best_state
);

  localparam int SW = $clog2(NUM_STATES);

  logic [PM_W-1:0]       pm     [NUM_STATES];
  logic [PM_W-1:0]       prev   [NUM_STATES];
  logic [PM_W-1:0]       new_pm [NUM_STATES];
  logic [PM_W-1:0]       norm   [NUM_STATES];
  logic [NUM_STATES-1:0] sel;
  logic [NUM_STATES-1:0] msb;
  logic                  all_msb;
  logic                  restart;

  assign restart = in_valid && frame_start;
  assign all_msb = &msb;

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_state
    localparam int P0 = pred0(s, NUM_STATES);
    localparam int P1 = pred1(s, NUM_STATES);

    assign prev[s] = restart ? PM_W'(init_metric(s, INIT_BIAS)) : pm[s];

    acs_node #(.BM_W(BM_W), .PM_W(PM_W)) u_acs (
      .pm0    (prev[P0]),
      .pm1    (prev[P1]),
      .bm0    (bm_flat[s*2*BM_W        +: BM_W]),
      .bm1    (bm_flat[s*2*BM_W + BM_W +: BM_W]),
      .new_pm (new_pm[s]),
      .sel    (sel[s])
    );

    // Dropping the shared MSB subtracts 2^(PM_W-1) from every metric at once.
    assign msb[s]  = new_pm[s][PM_W-1];
    assign norm[s] = {new_pm[s][PM_W-1] & ~all_msb, new_pm[s][PM_W-2:0]};
  end

`ifdef ACS_BEST_STATE_EN
  logic [PM_W-1:0] best_pm;
  logic [SW-1:0]   best_idx;

  // Strict less-than keeps the lowest index on equal metrics.
  always_comb begin
    best_pm  = norm[0];
    best_idx = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (norm[i] < best_pm) begin
        best_pm  = norm[i];
        best_idx = SW'(i);
      end
    end
  end
`endif

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the metric array is flops, so each entry is reset explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STATES; i++) pm[i] <= PM_W'(init_metric(i, INIT_BIAS));
      out_valid <= 1'b0;
      survivor  <= '0;
`ifdef ACS_BEST_STATE_EN
      best_state <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < NUM_STATES; i++) pm[i] <= norm[i];
        survivor <= sel;
`ifdef ACS_BEST_STATE_EN
        best_state <= best_idx;
`endif
      end
    end
  end

`ifndef ACS_BEST_STATE_EN
  assign best_state = '0;
`endif

endmodule
